// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encodings,
// RISC-V major opcodes, next-PC select codes and instruction classes.
package cpu_sequencer_pkg;

  // FSM state encodings
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_FWAIT  = 4'd2;
  localparam logic [3:0] ST_DECODE = 4'd3;
  localparam logic [3:0] ST_EXEC   = 4'd4;
  localparam logic [3:0] ST_MEM    = 4'd5;
  localparam logic [3:0] ST_MWAIT  = 4'd6;
  localparam logic [3:0] ST_WB     = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_L      = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b0000000;

  // Next-PC select codes
  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  // Instruction classes latched in DECODE
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_L    = 3'd3,
    CLS_S    = 3'd4,
    CLS_B    = 3'd5,
    CLS_JAL  = 3'd6,
    CLS_JALR = 3'd7
  } opclass_e;

  // Width of the shared FWAIT/MWAIT counter for a given worst-case latency
  function automatic int unsigned wait_cnt_width(input int unsigned max_lat);
    return $clog2(max_lat) + 32'd1;
  endfunction

  // JAL and JALR both redirect the PC to the jump target in WB
  function automatic logic is_jump(input opclass_e cls);
    return (cls == CLS_JAL) || (cls == CLS_JALR);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer and the lab datapath: run controls and
// decode inputs in one direction, phase strobes and status in the other.
interface cpu_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               run_en;
  logic               step_mode;
  logic               step;
  logic [6:0]         opcode;
  logic               branch_taken;
  logic               ir_we;
  logic               rf_we;
  logic               mem_rden;
  logic               mem_wren;
  logic               pc_we;
  logic [1:0]         pc_sel;
  logic               busy;
  logic               halted;
  logic               illegal;
  logic [COUNT_W-1:0] instr_count;

  modport slave (
    input  run_en, step_mode, step, opcode, branch_taken,
    output ir_we, rf_we, mem_rden, mem_wren, pc_we, pc_sel,
    output busy, halted, illegal, instr_count
  );

  modport master (
    output run_en, step_mode, step, opcode, branch_taken,
    input  ir_we, rf_we, mem_rden, mem_wren, pc_we, pc_sel,
    input  busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/cpu_sequencer_opclass_decode.sv
// Combinational opcode classifier; also intended for later pipeline decode.
module opclass_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   cls,
  output logic       valid
);

  // Map the major opcode onto its instruction class
  always_comb begin
    cls   = CLS_NONE;
    valid = 1'b0;
    case (opcode)
      OP_R:      begin cls = CLS_R;    valid = 1'b1; end
      OP_I:      begin cls = CLS_I;    valid = 1'b1; end
      OP_L:      begin cls = CLS_L;    valid = 1'b1; end
      OP_S:      begin cls = CLS_S;    valid = 1'b1; end
      OP_B_TYPE: begin cls = CLS_B;    valid = 1'b1; end
      OP_JAL:    begin cls = CLS_JAL;  valid = 1'b1; end
      OP_JALR:   begin cls = CLS_JALR; valid = 1'b1; end
      default:   begin cls = CLS_NONE; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps the datapath through fetch, decode,
// execute, memory and write-back, one instruction at a time.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int MEM_LAT = 1,
  parameter int COUNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  cpu_sequencer_if.slave bus
);

  localparam int MAX_LAT = (ROM_LAT > MEM_LAT) ? ROM_LAT : MEM_LAT;
  localparam int CNT_W   = int'(wait_cnt_width(MAX_LAT));
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  // Counter preloads: the wait phase ends when the counter reaches zero
  localparam logic [CNT_W-1:0] ROM_WAIT = CNT_W'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_WAIT = CNT_W'(MEM_LAT - 1);

  logic [3:0]         state_r, state_nx;
  opclass_e           cls_r, cls_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic               illegal_r, illegal_nx;
  logic [COUNT_W-1:0] instr_count_r;

  opclass_e           dec_cls_s;
  logic               dec_valid_s;
  logic               start_s;
  logic               cont_s;
  logic               cnt_last_s;
  logic [3:0]         after_retire_s;

  logic               ir_we_s, rf_we_s, mem_rden_s, mem_wren_s, pc_we_s;
  logic [1:0]         pc_sel_s;

  opclass_decode u_decode (
    .opcode (bus.opcode),
    .cls    (dec_cls_s),
    .valid  (dec_valid_s)
  );

  assign start_s        = (bus.run_en & ~bus.step_mode) | (bus.step_mode & bus.step);
  assign cont_s         = bus.run_en & ~bus.step_mode;
  assign cnt_last_s     = (cnt_r == CNT_ZERO);
  assign after_retire_s = cont_s ? ST_FETCH : ST_IDLE;

  // Next state, class latch, shared wait counter and sticky illegal flag
  always_comb begin
    state_nx   = state_r;
    cls_nx     = cls_r;
    cnt_nx     = cnt_r;
    illegal_nx = illegal_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx = ST_FETCH;
        else         state_nx = ST_IDLE;
      end
      ST_FETCH: begin
        state_nx = ST_FWAIT;
        cnt_nx   = ROM_WAIT;
      end
      ST_FWAIT: begin
        if (cnt_last_s) state_nx = ST_DECODE;
        else            cnt_nx   = cnt_r - CNT_ONE;
      end
      ST_DECODE: begin
        if (dec_valid_s) begin
          cls_nx   = dec_cls_s;
          state_nx = ST_EXEC;
        end else begin
          // An all-zero word is a deliberate stop; anything else is illegal
          state_nx   = ST_HALT;
          illegal_nx = (bus.opcode != OP_HALT);
        end
      end
      ST_EXEC: begin
        case (cls_r)
          CLS_R, CLS_I, CLS_JAL, CLS_JALR: state_nx = ST_WB;
          CLS_L, CLS_S:                    state_nx = ST_MEM;
          CLS_B:                           state_nx = after_retire_s;
          default:                         state_nx = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (cls_r == CLS_S) begin
          state_nx = after_retire_s;
        end else if (cls_r == CLS_L) begin
          state_nx = ST_MWAIT;
          cnt_nx   = MEM_WAIT;
        end else begin
          state_nx = ST_HALT;
        end
      end
      ST_MWAIT: begin
        if (cnt_last_s) state_nx = ST_WB;
        else            cnt_nx   = cnt_r - CNT_ONE;
      end
      ST_WB:   state_nx = after_retire_s;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Phase strobes decoded from state, latched class and wait counter
  always_comb begin
    ir_we_s    = 1'b0;
    rf_we_s    = 1'b0;
    mem_rden_s = 1'b0;
    mem_wren_s = 1'b0;
    pc_we_s    = 1'b0;
    pc_sel_s   = PC_SEL_SEQ;
    case (state_r)
      ST_FWAIT: ir_we_s = cnt_last_s;
      ST_EXEC: begin
        if (cls_r == CLS_B) begin
          pc_we_s  = 1'b1;
          pc_sel_s = bus.branch_taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
        end else begin
          pc_we_s  = 1'b0;
        end
      end
      ST_MEM: begin
        if (cls_r == CLS_S) begin
          mem_wren_s = 1'b1;
          pc_we_s    = 1'b1;
        end else if (cls_r == CLS_L) begin
          mem_rden_s = 1'b1;
        end else begin
          mem_rden_s = 1'b0;
        end
      end
      ST_MWAIT: mem_rden_s = 1'b1;
      ST_WB: begin
        rf_we_s  = 1'b1;
        pc_we_s  = 1'b1;
        pc_sel_s = is_jump(cls_r) ? PC_SEL_JUMP : PC_SEL_SEQ;
      end
      default: pc_sel_s = PC_SEL_SEQ;
    endcase
  end

  // State, class, counter, sticky flag and retired-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cls_r         <= CLS_NONE;
      cnt_r         <= CNT_ZERO;
      illegal_r     <= 1'b0;
      instr_count_r <= {COUNT_W{1'b0}};
    end else begin
      state_r   <= state_nx;
      cls_r     <= cls_nx;
      cnt_r     <= cnt_nx;
      illegal_r <= illegal_nx;
      // pc_we fires exactly once per instruction, so it marks retirement
      if (pc_we_s) instr_count_r <= instr_count_r + COUNT_W'(1'b1);
      else         instr_count_r <= instr_count_r;
    end
  end

  assign bus.ir_we       = ir_we_s;
  assign bus.rf_we       = rf_we_s;
  assign bus.mem_rden    = mem_rden_s;
  assign bus.mem_wren    = mem_wren_s;
  assign bus.pc_we       = pc_we_s;
  assign bus.pc_sel      = pc_sel_s;
  assign bus.busy        = (state_r != ST_IDLE) && (state_r != ST_HALT);
  assign bus.halted      = (state_r == ST_HALT);
  assign bus.illegal     = illegal_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-instruction schedule model
// checked every cycle, a latency table, and directed corner sequences.
module tb_cpu_sequencer;

  localparam int ROM_LAT = 1;
  localparam int MEM_LAT = 2;
  localparam int COUNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

  cpu_sequencer #(.ROM_LAT(ROM_LAT), .MEM_LAT(MEM_LAT), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One expected cycle of an instruction's life
  typedef struct packed {
    logic       ir;
    logic       rf;
    logic       rd;
    logic       wr;
    logic       pcwe;
    logic [1:0] sel;
    logic       br;   // pc_sel follows branch_taken this cycle
    logic       dec;  // opcode is classified this cycle
  } ent_t;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    int         lat;
    logic [1:0] sel;
    int         rf;
    int         rd;
    int         wr;
  } vec_t;

  ent_t               sched[$];
  logic               m_valid = 1'b0;
  logic               m_halt;
  logic               m_ill;
  logic [COUNT_W-1:0] m_cnt;
  int                 n_cmp = 0;
  int                 n_fail = 0;

  logic       last_ir, last_rf, last_rd, last_wr, last_pcwe;
  logic [1:0] last_sel;

  vec_t       tbl[8];
  logic [6:0] legal[7];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic ent_t mk(input logic ir, input logic rf, input logic rd, input logic wr,
                              input logic pcwe, input logic [1:0] sel, input logic br, input logic dec);
    ent_t e;
    e = '{ir, rf, rd, wr, pcwe, sel, br, dec};
    return e;
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return 1;  // R
      7'b0010011: return 2;  // I
      7'b0000011: return 3;  // load
      7'b0100011: return 4;  // store
      7'b1100011: return 5;  // branch
      7'b1101111: return 6;  // JAL
      7'b1100111: return 7;  // JALR
      default:    return 0;
    endcase
  endfunction

  // Fetch, ROM wait (IR loads on its last cycle) and decode
  function automatic void push_prefix();
    sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < ROM_LAT; i++)
      sched.push_back(mk(i == ROM_LAT - 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
  endfunction

  // Remaining cycles from execute onward, by instruction class
  function automatic void push_class(input int c);
    ent_t nop;
    nop = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    case (c)
      1, 2: begin
        sched.push_back(nop);
        sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0));
      end
      3: begin
        sched.push_back(nop);
        for (int i = 0; i < MEM_LAT + 1; i++)
          sched.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
        sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0));
      end
      4: begin
        sched.push_back(nop);
        sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
      end
      5: sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
      default: begin
        sched.push_back(nop);
        sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
      end
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic ir, input logic rf, input logic rd, input logic wr,
                                       input logic pcwe, input logic [1:0] sel, input logic busy,
                                       input logic hlt, input logic ill, input logic [COUNT_W-1:0] cnt);
    return 32'({ir, rf, rd, wr, pcwe, sel, busy, hlt, ill, cnt});
  endfunction

  function automatic logic [31:0] obs();
    return pack(bus.ir_we, bus.rf_we, bus.mem_rden, bus.mem_wren, bus.pc_we, bus.pc_sel,
                bus.busy, bus.halted, bus.illegal, bus.instr_count);
  endfunction

  function automatic logic [31:0] model_exp();
    ent_t       e;
    logic [1:0] s;
    if (m_halt || sched.size() == 0)
      return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, m_halt, m_ill, m_cnt);
    e = sched[0];
    s = e.br ? {1'b0, bus.branch_taken} : e.sel;
    return pack(e.ir, e.rf, e.rd, e.wr, e.pcwe, s, 1'b1, 1'b0, m_ill, m_cnt);
  endfunction

  // Advance the model across one rising edge using this cycle's inputs
  function automatic void model_step();
    ent_t e;
    int   c;
    if (rst) begin
      sched.delete();
      m_halt  = 1'b0;
      m_ill   = 1'b0;
      m_cnt   = '0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halt) begin
      if (sched.size() == 0) begin
        if ((bus.run_en && !bus.step_mode) || (bus.step_mode && bus.step)) push_prefix();
      end else begin
        e = sched.pop_front();
        if (e.dec) begin
          c = classify(bus.opcode);
          if (c == 0) begin
            m_halt = 1'b1;
            m_ill  = (bus.opcode != 7'd0);
            sched.delete();
          end else begin
            push_class(c);
          end
        end
        if (e.pcwe) begin
          m_cnt = m_cnt + 1'b1;
          if (bus.run_en && !bus.step_mode) push_prefix();
        end
      end
    end
  endfunction

  // One clock: compare against the model, record strobes, cross the edge
  task automatic tick();
    logic [31:0] act;
    #1;
    act = obs();
    if (m_valid) check("cycle_model", act, model_exp());
    last_ir   = bus.ir_we;
    last_rf   = bus.rf_we;
    last_rd   = bus.mem_rden;
    last_wr   = bus.mem_wren;
    last_pcwe = bus.pc_we;
    last_sel  = bus.pc_sel;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [19:0] ir_m, rf_m, pc_m;
    int lat, rf, rd, wr, npc, hold;
    logic [1:0] sel;
    logic [6:0] r;

    tbl[0] = '{7'b0110011, 1'b0, 5, 2'd0, 1, 0, 0};
    tbl[1] = '{7'b0010011, 1'b0, 5, 2'd0, 1, 0, 0};
    tbl[2] = '{7'b0000011, 1'b0, 8, 2'd0, 1, 3, 0};
    tbl[3] = '{7'b0100011, 1'b0, 5, 2'd0, 0, 0, 1};
    tbl[4] = '{7'b1100011, 1'b1, 4, 2'd1, 0, 0, 0};
    tbl[5] = '{7'b1100011, 1'b0, 4, 2'd0, 0, 0, 0};
    tbl[6] = '{7'b1101111, 1'b0, 5, 2'd2, 1, 0, 0};
    tbl[7] = '{7'b1100111, 1'b1, 5, 2'd2, 1, 0, 0};
    legal  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
               7'b1100011, 7'b1101111, 7'b1100111};

    rst = 1'b1;
    bus.run_en = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
    bus.opcode = 7'b0110011; bus.branch_taken = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("reset_state", obs(), 32'd0);

    // Continuous run of R-type instructions
    bus.run_en = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      ir_m[c-1] = last_ir;
      rf_m[c-1] = last_rf;
      pc_m[c-1] = last_pcwe;
    end
    check("run_ir_cycles", 32'(ir_m), 32'h10842);
    check("run_rf_cycles", 32'(rf_m), 32'h84210);
    check("run_pc_cycles", 32'(pc_m), 32'h84210);
    check("run_count20", 32'(bus.instr_count), 32'd4);
    tick();
    bus.run_en = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("run_drop_idle", 32'({bus.busy, bus.instr_count}), 32'd5);

    // Latency table in single-step mode
    foreach (tbl[k]) begin
      do_reset();
      bus.step_mode = 1'b1; bus.run_en = 1'b0;
      bus.opcode = tbl[k].op; bus.branch_taken = tbl[k].bt;
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      lat = 0; rf = 0; rd = 0; wr = 0; sel = 2'd3;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        tick();
        if (last_rd) rd++;
        if (last_wr) wr++;
        if (last_pcwe) begin lat = c; sel = last_sel; rf = int'(last_rf); end
      end
      check($sformatf("tbl%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
      check($sformatf("tbl%0d_pc_sel", k), 32'(sel), 32'(tbl[k].sel));
      check($sformatf("tbl%0d_rf_we", k), 32'(rf), 32'(tbl[k].rf));
      check($sformatf("tbl%0d_rden_cycles", k), 32'(rd), 32'(tbl[k].rd));
      check($sformatf("tbl%0d_wren_cycles", k), 32'(wr), 32'(tbl[k].wr));
      check($sformatf("tbl%0d_done", k), 32'({bus.busy, bus.instr_count}), 32'd1);
    end

    // Single step: a pulse while busy is dropped, not queued
    do_reset();
    bus.step_mode = 1'b1; bus.run_en = 1'b1; bus.opcode = 7'b0110011;
    tick();
    check("step_no_pulse_idle", 32'(bus.busy), 32'd0);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    tick();
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("step_one_instr", 32'({bus.busy, bus.instr_count}), 32'd1);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("step_second_instr", 32'({bus.busy, bus.instr_count}), 32'd2);

    // Halt on zero opcode and on an unknown opcode
    do_reset();
    bus.step_mode = 1'b0; bus.run_en = 1'b1; bus.opcode = 7'b0000000;
    for (int c = 0; c < 5; c++) tick();
    check("halt_zero", 32'({bus.halted, bus.illegal, bus.busy}), 32'b100);
    bus.step = 1'b1; bus.step_mode = 1'b1; tick(); tick();
    bus.step = 1'b0; bus.step_mode = 1'b0; bus.opcode = 7'b0110011;
    for (int c = 0; c < 6; c++) tick();
    check("halt_absorbing", 32'({bus.halted, bus.instr_count}), 32'h10);
    do_reset();
    check("halt_rst_clears", 32'({bus.halted, bus.illegal}), 32'd0);
    bus.opcode = 7'b1111111;
    for (int c = 0; c < 5; c++) tick();
    check("halt_illegal", 32'({bus.halted, bus.illegal}), 32'b11);
    do_reset();
    check("illegal_rst_clears", obs(), 32'd0);

    // Reset in MWAIT of the second load
    bus.run_en = 1'b1; bus.opcode = 7'b0000011;
    for (int c = 0; c < 9; c++) tick();
    check("mwait_first_retired", 32'(bus.instr_count), 32'd1);
    for (int c = 0; c < 5; c++) tick();
    check("mwait_reached", 32'({bus.mem_rden, bus.busy}), 32'b11);
    do_reset();
    check("mwait_rst_clean", obs(), 32'd0);

    // Counter wrap with back-to-back branches
    bus.opcode = 7'b1100011; npc = 0;
    tick();
    for (int c = 0; c < 60; c++) begin
      bus.branch_taken = 1'($urandom_range(0, 1));
      tick();
      if (last_pcwe) npc++;
    end
    check("wrap_count15", 32'(bus.instr_count), 32'd15);
    for (int c = 0; c < 4; c++) begin tick(); if (last_pcwe) npc++; end
    check("wrap_count0", 32'(bus.instr_count), 32'd0);
    check("wrap_pc_we_total", 32'(npc), 32'd16);

    // Randomised run against the schedule model
    do_reset();
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0) || (hold > 6);
      bus.run_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) bus.step_mode = ~bus.step_mode;
      bus.step = ($urandom_range(0, 3) == 0);
      r = 7'($urandom_range(0, 31));
      if (r < 7'd28) bus.opcode = legal[r % 7'd7];
      else if (r == 7'd28) bus.opcode = 7'd0;
      else bus.opcode = 7'($urandom);
      bus.branch_taken = 1'($urandom_range(0, 1));
      tick();
      if (bus.halted) hold++;
      else hold = 0;
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the lab RISC-V datapath (PC, instruction ROM, reg_file, ALU, lab5_ram). It replaces free-running single-cycle PC update with an explicit FSM. The FSM issues one-hot strobes per phase: IR load, reg_file write, RAM read/write, PC write with next-PC select. It supports continuous run, single-step and halt-on-unknown-opcode, and counts retired instructions. It sits beside control_unit; control_unit still supplies ALUSrc, MemtoReg and aluop.

Parameters:
ROM_LAT, 1, instruction ROM read latency in cycles (1..3)
MEM_LAT, 1, data RAM read latency in cycles (1..3)
COUNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  single system clock; all state on rising edge
rst  in  1  synchronous reset, active-high
run_en  in  1  level; enables continuous execution
step_mode  in  1  1 = single-step; one instruction per step pulse
step  in  1  single-cycle pulse; starts one instruction in step_mode
opcode  in  7  instr[6:0] from IR; valid from DECODE onward
branch_taken  in  1  funct3[0] XOR ALU zero; sampled in EXEC
ir_we  out  1  load instruction register
rf_we  out  1  reg_file write enable
mem_rden  out  1  RAM read enable
mem_wren  out  1  RAM write enable
pc_we  out  1  PC write; exactly one cycle per retired instruction
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target (JAL/JALR)
busy  out  1  state not IDLE and not HALT
halted  out  1  in HALT
illegal  out  1  sticky; halt caused by a nonzero unrecognised opcode
instr_count  out  COUNT_W  retired instructions; wraps to 0

Behaviour:
- Reset: state IDLE, class register cleared, instr_count 0. All strobes, busy, halted and illegal are 0, with pc_sel 0. Reset wins over every other input, including mid-instruction: the cycle after rst shows no strobes.
- Outputs are decoded from the state register, the latched opcode class and the wait counter. pc_sel in EXEC of a branch additionally follows branch_taken.
- States: IDLE, FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT.
- IDLE -> FETCH when (run_en & ~step_mode) | (step_mode & step). Otherwise stay in IDLE.
- FETCH: 1 cycle. PC is stable at the ROM address.
- FWAIT: ROM_LAT cycles; ir_we=1 in the last of them.
- DECODE: 1 cycle. Classify opcode into R(0110011), I(0010011), L(0000011), S(0100011), B(1100011), JAL(1101111), JALR(1100111) and latch the class.
  - Opcode 0000000 -> HALT.
  - Any other unknown opcode -> HALT and set illegal.
  - Recognised opcode -> EXEC.
- EXEC: 1 cycle.
  - R/I/JAL/JALR -> WB.
  - L/S -> MEM.
  - B: pc_we=1, pc_sel = branch_taken ? 1 : 0; retire.
- MEM:
  - S: mem_wren=1, pc_we=1, pc_sel=0; retire.
  - L: mem_rden=1 -> MWAIT.
- MWAIT: MEM_LAT cycles with mem_rden held at 1 -> WB.
- WB: rf_we=1, pc_we=1; retire.
  - pc_sel=2 for JAL/JALR.
  - pc_sel=0 otherwise.
- Retire: instr_count+1 (modulo 2^COUNT_W). Next state:
  - FETCH if run_en & ~step_mode.
  - IDLE otherwise.
- Latency with ROM_LAT=MEM_LAT=1, counted from the FETCH cycle:
  - B: 4 cycles.
  - R, I, S, JAL, JALR: 5 cycles.
  - L: 7 cycles; each extra latency cycle adds 1.
- run_en dropping mid-instruction: the instruction completes, then the FSM returns to IDLE.
- step outside IDLE is ignored; it is not queued.
- HALT: absorbing state; halted=1, no strobes, instr_count frozen. Only rst exits.
- step_mode changes take effect at the next retire or IDLE decision.
- At most one of mem_rden/mem_wren is asserted in any cycle. ir_we, rf_we and mem_wren never coincide.

Decomposition:
- Shared header seq_defs.vh holds:
  - state encodings;
  - opcode localparams (R, I, S, L, B_type, JAL, JALR);
  - pc_sel codes;
  - class codes.
- Sub-module opclass_decode: combinational, maps opcode[6:0] to a class code plus a valid flag. It is shared with future pipeline work.
- A single wait counter of width clog2(max latency)+1 is reused by FWAIT and MWAIT.

Test Plan:
- Run, R opcode: rst, then run_en=1, step_mode=0, opcode=0110011 held -> ir_we at cycle 2, rf_we and pc_we at cycle 5, pc_we every 5 cycles, instr_count=4 after 20 cycles.
- Load with MEM_LAT=2: opcode=0000011 -> mem_rden high cycles 5-7, rf_we and pc_we at cycle 8, pc_sel=0.
- Branch: opcode=1100011 with branch_taken=1 -> pc_we with pc_sel=1 at cycle 4. Repeat with branch_taken=0 -> pc_sel=0. JAL gives pc_sel=2 together with rf_we.
- Single step: step_mode=1, one step pulse -> exactly one instruction, FSM back in IDLE, instr_count+1. A second step pulse while busy is ignored; a pulse after IDLE runs the next instruction.
- Halt: opcode=0000000 -> halted=1, illegal=0, no further strobes despite run_en/step. opcode=1111111 -> halted=1, illegal=1. rst clears both.
- Reset and wrap: rst during MWAIT -> next cycle all strobes 0, busy=0, instr_count=0. With COUNT_W=4, 16 retires -> instr_count=0.
